// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: jump-type encoding, register index width and
// the control-field bubble that the ID/EX register loads when it is squashed.
package riscv_pipe_pkg;

   localparam int REG_W = 5;

   localparam logic [1:0] NO_JUMP = 2'b00;
   localparam logic [1:0] JAL     = 2'b01;
   localparam logic [1:0] JAL_R   = 2'b10;

   typedef struct packed {
      logic             valid;
      logic             reg_we;
      logic             mem_read;
      logic             mem_we;
      logic [1:0]       jump_t;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
   } ex_ctl_t;

   // Register indices are zeroed too, so the forwarding unit never matches a bubble.
   localparam ex_ctl_t BUBBLE_CTL = '{
      valid:    1'b0,
      reg_we:   1'b0,
      mem_read: 1'b0,
      mem_we:   1'b0,
      jump_t:   NO_JUMP,
      rs1:      '0,
      rs2:      '0,
      rd:       '0
   };

endpackage

// File: rtl/id_ex_stage_sat_counter.sv
// Saturating event counter: counts inc pulses, freezes on hold, sticks at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (!hold && inc && !(&count_q)) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, redirect flushing
// and saturating stall/flush event counters.
module id_ex_stage
   import riscv_pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ext_stall,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [REG_W-1:0]  id_rs1,
   input  logic [REG_W-1:0]  id_rs2,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [XLEN-1:0]   id_rd1,
   input  logic [XLEN-1:0]   id_rd2,
   input  logic [XLEN-1:0]   id_imm,
   input  logic              id_reg_we,
   input  logic              id_mem_read,
   input  logic              id_mem_we,
   input  logic [1:0]        id_jump_t,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              ex_redirect,
   output logic              ex_valid,
   output logic              ex_reg_we,
   output logic              ex_mem_read,
   output logic              ex_mem_we,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rd1,
   output logic [XLEN-1:0]   ex_rd2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [REG_W-1:0]  ex_rs1,
   output logic [REG_W-1:0]  ex_rs2,
   output logic [REG_W-1:0]  ex_rd,
   output logic [1:0]        ex_jump_t,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              stall_pc,
   output logic              stall_ifid,
   output logic              flush_ifid,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   ex_ctl_t           ctl_d, ctl_q;
   logic [XLEN-1:0]   pc_d, pc_q;
   logic [XLEN-1:0]   rd1_d, rd1_q;
   logic [XLEN-1:0]   rd2_d, rd2_q;
   logic [XLEN-1:0]   imm_d, imm_q;
   logic [CTRL_W-1:0] ctrl_d, ctrl_q;
   logic              lu;

   // ex_valid qualifies every ex_* field: side effects (reg_we, mem_*) are only
   // ever set together with valid, so consumers may act on them directly.
   always_comb begin
      lu = ctl_q.valid & ctl_q.mem_read & (ctl_q.rd != '0) & id_valid &
           ((ctl_q.rd == id_rs1) | (ctl_q.rd == id_rs2));
   end

   // A redirect makes the ID instruction wrong-path, so it overrides a load-use stall.
   assign stall_pc   = ext_stall | (~ex_redirect & lu);
   assign stall_ifid = stall_pc;
   assign flush_ifid = ~ext_stall & ex_redirect;

   always_comb begin
      ctl_d  = ctl_q;
      pc_d   = pc_q;
      rd1_d  = rd1_q;
      rd2_d  = rd2_q;
      imm_d  = imm_q;
      ctrl_d = ctrl_q;
      if (!ext_stall) begin
         if (ex_redirect || lu) begin
            ctl_d  = BUBBLE_CTL;
            pc_d   = '0;
            rd1_d  = '0;
            rd2_d  = '0;
            imm_d  = '0;
            ctrl_d = '0;
         end else begin
            ctl_d.valid    = id_valid;
            ctl_d.reg_we   = id_valid & id_reg_we;
            ctl_d.mem_read = id_valid & id_mem_read;
            ctl_d.mem_we   = id_valid & id_mem_we;
            ctl_d.jump_t   = id_jump_t;
            ctl_d.rs1      = id_rs1;
            ctl_d.rs2      = id_rs2;
            ctl_d.rd       = id_rd;
            pc_d           = id_pc;
            rd1_d          = id_rd1;
            rd2_d          = id_rd2;
            imm_d          = id_imm;
            ctrl_d         = id_ctrl;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctl_q  <= BUBBLE_CTL;
         pc_q   <= '0;
         rd1_q  <= '0;
         rd2_q  <= '0;
         imm_q  <= '0;
         ctrl_q <= '0;
      end else begin
         ctl_q  <= ctl_d;
         pc_q   <= pc_d;
         rd1_q  <= rd1_d;
         rd2_q  <= rd2_d;
         imm_q  <= imm_d;
         ctrl_q <= ctrl_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .hold  (ext_stall),
      .inc   (lu & ~ex_redirect),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .hold  (ext_stall),
      .inc   (ex_redirect),
      .count (flush_cnt)
   );

   assign ex_valid    = ctl_q.valid;
   assign ex_reg_we   = ctl_q.reg_we;
   assign ex_mem_read = ctl_q.mem_read;
   assign ex_mem_we   = ctl_q.mem_we;
   assign ex_jump_t   = ctl_q.jump_t;
   assign ex_rs1      = ctl_q.rs1;
   assign ex_rs2      = ctl_q.rs2;
   assign ex_rd       = ctl_q.rd;
   assign ex_pc       = pc_q;
   assign ex_rd1      = rd1_q;
   assign ex_rd2      = rd2_q;
   assign ex_imm      = imm_q;
   assign ex_ctrl     = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: each step drives ID inputs and queues the
// hand-computed mid-cycle view; a negedge monitor pops and compares.
module tb_id_ex_stage;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 16;
   localparam int CNT_W  = 4;
   localparam int EXP_W  = 64;

   logic              clk;
   logic              rst;
   logic              ext_stall;
   logic              id_valid;
   logic [XLEN-1:0]   id_pc;
   logic [4:0]        id_rs1, id_rs2, id_rd;
   logic [XLEN-1:0]   id_rd1, id_rd2, id_imm;
   logic              id_reg_we, id_mem_read, id_mem_we;
   logic [1:0]        id_jump_t;
   logic [CTRL_W-1:0] id_ctrl;
   logic              ex_redirect;
   logic              ex_valid, ex_reg_we, ex_mem_read, ex_mem_we;
   logic [XLEN-1:0]   ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]        ex_rs1, ex_rs2, ex_rd;
   logic [1:0]        ex_jump_t;
   logic [CTRL_W-1:0] ex_ctrl;
   logic              stall_pc, stall_ifid, flush_ifid;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   logic [EXP_W-1:0] exp_q[$];
   string            name_q[$];
   int               checks;
   int               failures;

   id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .ext_stall   (ext_stall),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rd       (id_rd),
      .id_rd1      (id_rd1),
      .id_rd2      (id_rd2),
      .id_imm      (id_imm),
      .id_reg_we   (id_reg_we),
      .id_mem_read (id_mem_read),
      .id_mem_we   (id_mem_we),
      .id_jump_t   (id_jump_t),
      .id_ctrl     (id_ctrl),
      .ex_redirect (ex_redirect),
      .ex_valid    (ex_valid),
      .ex_reg_we   (ex_reg_we),
      .ex_mem_read (ex_mem_read),
      .ex_mem_we   (ex_mem_we),
      .ex_pc       (ex_pc),
      .ex_rd1      (ex_rd1),
      .ex_rd2      (ex_rd2),
      .ex_imm      (ex_imm),
      .ex_rs1      (ex_rs1),
      .ex_rs2      (ex_rs2),
      .ex_rd       (ex_rd),
      .ex_jump_t   (ex_jump_t),
      .ex_ctrl     (ex_ctrl),
      .stall_pc    (stall_pc),
      .stall_ifid  (stall_ifid),
      .flush_ifid  (flush_ifid),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // driver
   task automatic step(input logic r, input logic xs, input logic redir,
                       input logic v, input logic [31:0] pc,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic mr, input logic mw, input logic [1:0] jt);
      @(posedge clk);
      #2;
      rst         = r;
      ext_stall   = xs;
      ex_redirect = redir;
      id_valid    = v;
      id_pc       = pc;
      id_rs1      = rs1;
      id_rs2      = rs2;
      id_rd       = rd;
      id_reg_we   = we;
      id_mem_read = mr;
      id_mem_we   = mw;
      id_jump_t   = jt;
      id_rd1      = $urandom;
      id_rd2      = $urandom;
      id_imm      = $urandom;
      id_ctrl     = CTRL_W'($urandom_range(0, 65535));
   endtask

   task automatic expect_view(input string name,
                              input logic v, input logic we, input logic mr, input logic mw,
                              input logic [1:0] jt, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [31:0] pc,
                              input logic st, input logic fl,
                              input logic [3:0] sc, input logic [3:0] fc);
      exp_q.push_back({v, we, mr, mw, jt, rs1, rs2, rd, pc, st, st, fl, sc, fc});
      name_q.push_back(name);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [EXP_W-1:0] got, want;
      string            nm;
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         nm   = name_q.pop_front();
         got  = {ex_valid, ex_reg_we, ex_mem_read, ex_mem_we, ex_jump_t, ex_rs1, ex_rs2,
                 ex_rd, ex_pc, stall_pc, stall_ifid, flush_ifid, stall_cnt, flush_cnt};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%h want=%h", nm, got, want);
         end
      end
   end

   initial begin
      int waited;
      checks      = 0;
      failures    = 0;
      rst         = 1'b1;
      ext_stall   = 1'b0;
      ex_redirect = 1'b0;
      id_valid    = 1'b0;
      id_pc       = '0;
      id_rs1      = '0;
      id_rs2      = '0;
      id_rd       = '0;
      id_reg_we   = 1'b0;
      id_mem_read = 1'b0;
      id_mem_we   = 1'b0;
      id_jump_t   = 2'b00;
      id_rd1      = '0;
      id_rd2      = '0;
      id_imm      = '0;
      id_ctrl     = '0;

      // reset with random ID contents
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 0, 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1, 1, 1, 2'b01);
         expect_view("reset", 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0, 0, 0, 4'd0, 4'd0);
      end

      // pass-through of a JAL
      step(0, 0, 0, 1, 32'h100, 5, 6, 7, 1, 0, 0, 2'b01);
      expect_view("post_reset", 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0, 0, 0, 4'd0, 4'd0);
      step(0, 0, 0, 1, 32'h104, 1, 0, 3, 1, 1, 0, 2'b00);               // lw x3
      expect_view("pass_through", 1, 1, 0, 0, 2'b01, 5, 6, 7, 32'h100, 0, 0, 4'd0, 4'd0);

      // load-use: add x4,x3,x1 behind lw x3
      step(0, 0, 0, 1, 32'h108, 3, 1, 4, 1, 0, 0, 2'b00);
      expect_view("lu_detect", 1, 1, 1, 0, 2'b00, 1, 0, 3, 32'h104, 1, 0, 4'd0, 4'd0);
      step(0, 0, 0, 1, 32'h108, 3, 1, 4, 1, 0, 0, 2'b00);
      expect_view("lu_bubble", 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0, 0, 0, 4'd1, 4'd0);
      step(0, 0, 0, 1, 32'h10c, 2, 0, 0, 1, 1, 0, 2'b00);               // lw x0
      expect_view("lu_resume", 1, 1, 0, 0, 2'b00, 3, 1, 4, 32'h108, 0, 0, 4'd1, 4'd0);

      // load to x0 never stalls
      step(0, 0, 0, 1, 32'h110, 0, 0, 5, 1, 0, 0, 2'b00);
      expect_view("load_x0", 1, 1, 1, 0, 2'b00, 2, 0, 0, 32'h10c, 0, 0, 4'd1, 4'd0);

      // redirect coinciding with load-use
      step(0, 0, 0, 1, 32'h114, 1, 2, 8, 1, 1, 0, 2'b00);               // lw x8
      expect_view("load_x0_after", 1, 1, 0, 0, 2'b00, 0, 0, 5, 32'h110, 0, 0, 4'd1, 4'd0);
      step(0, 0, 1, 1, 32'h118, 8, 0, 9, 1, 0, 0, 2'b00);
      expect_view("redir_lu", 1, 1, 1, 0, 2'b00, 1, 2, 8, 32'h114, 0, 1, 4'd1, 4'd0);
      step(0, 0, 0, 0, 32'h200, 8, 8, 10, 1, 1, 1, 2'b00);              // invalid, side effects set
      expect_view("redir_bubble", 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0, 0, 0, 4'd1, 4'd1);
      step(0, 0, 0, 1, 32'h300, 0, 0, 11, 1, 1, 0, 2'b00);              // lw x11
      expect_view("invalid_forced", 0, 0, 0, 0, 2'b00, 8, 8, 10, 32'h200, 0, 0, 4'd1, 4'd1);

      // ext_stall over a load-use, with a redirect during the freeze
      step(0, 1, 0, 1, 32'h304, 11, 0, 12, 1, 0, 0, 2'b00);
      expect_view("xstall_1", 1, 1, 1, 0, 2'b00, 0, 0, 11, 32'h300, 1, 0, 4'd1, 4'd1);
      step(0, 1, 1, 1, 32'h304, 11, 0, 12, 1, 0, 0, 2'b00);
      expect_view("xstall_2", 1, 1, 1, 0, 2'b00, 0, 0, 11, 32'h300, 1, 0, 4'd1, 4'd1);
      step(0, 1, 0, 1, 32'h304, 11, 0, 12, 1, 0, 0, 2'b00);
      expect_view("xstall_3", 1, 1, 1, 0, 2'b00, 0, 0, 11, 32'h300, 1, 0, 4'd1, 4'd1);
      step(0, 0, 0, 1, 32'h304, 11, 0, 12, 1, 0, 0, 2'b00);
      expect_view("xstall_release", 1, 1, 1, 0, 2'b00, 0, 0, 11, 32'h300, 1, 0, 4'd1, 4'd1);
      step(0, 0, 0, 1, 32'h304, 11, 0, 12, 1, 0, 0, 2'b00);
      expect_view("xstall_bubble", 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0, 0, 0, 4'd2, 4'd1);
      step(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 2'b00);
      expect_view("xstall_resume", 1, 1, 0, 0, 2'b00, 11, 0, 12, 32'h304, 0, 0, 4'd2, 4'd1);

      // drive 14 more load-use events: stall_cnt would reach 16, must stop at 15
      for (int k = 0; k < 14; k++) begin
         step(0, 0, 0, 1, 32'h400, 1, 0, 13, 1, 1, 0, 2'b00);
         step(0, 0, 0, 1, 32'h404, 13, 0, 14, 1, 0, 0, 2'b10);
         step(0, 0, 0, 1, 32'h404, 13, 0, 14, 1, 0, 0, 2'b10);
      end
      step(0, 0, 0, 1, 32'h400, 1, 0, 13, 1, 1, 0, 2'b00);
      expect_view("sat_reached", 1, 1, 0, 0, 2'b10, 13, 0, 14, 32'h404, 0, 0, 4'd15, 4'd1);
      step(0, 0, 0, 1, 32'h404, 13, 0, 14, 1, 0, 0, 2'b10);
      expect_view("sat_lu", 1, 1, 1, 0, 2'b00, 1, 0, 13, 32'h400, 1, 0, 4'd15, 4'd1);
      step(0, 0, 0, 1, 32'h404, 13, 0, 14, 1, 0, 0, 2'b10);
      expect_view("sat_hold", 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0, 0, 0, 4'd15, 4'd1);

      // reset asserted while a load-use stall is pending
      step(0, 0, 0, 1, 32'h500, 1, 0, 15, 1, 1, 0, 2'b00);
      step(1, 0, 0, 1, 32'h504, 15, 0, 16, 1, 0, 0, 2'b00);
      step(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 2'b00);
      expect_view("reset_mid_stall", 0, 0, 0, 0, 2'b00, 0, 0, 0, 32'h0, 0, 0, 4'd0, 4'd0);

      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: pending=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus load-use hazard controller for the 5-stage RISC-V core.
- Captures decoded ID-stage fields and drives the EX-stage rs1/rs2/rd/reg_we/jump_t fields consumed by the data-forwarding unit.
- Generates PC/IF-ID stall and IF/ID flush; inserts bubbles on load-use hazards and on EX-resolved redirects.
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
- XLEN, 32, datapath width (PC, operands, immediate)
- CTRL_W, 16, width of the opaque ALU/mem control bundle passed through
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- ext_stall  in  1  global freeze (memory wait); holds every register in this block
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of the ID instruction
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_rd1, id_rd2  in  XLEN each  register-file read data
- id_imm  in  XLEN  immediate
- id_reg_we  in  1  writes rd
- id_mem_read  in  1  is a load
- id_mem_we  in  1  is a store
- id_jump_t  in  2  NO_JUMP/JAL/JAL_R
- id_ctrl  in  CTRL_W  remaining control bundle
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle
- ex_valid, ex_reg_we, ex_mem_read, ex_mem_we  out  1 each  registered EX fields
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  XLEN each  registered EX fields
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered EX fields, to the forwarding unit
- ex_jump_t  out  2  registered EX field
- ex_ctrl  out  CTRL_W  registered EX field
- stall_pc  out  1  hold PC (combinational)
- stall_ifid  out  1  hold IF/ID register (combinational)
- flush_ifid  out  1  clear IF/ID register to a bubble (combinational)
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset: synchronous, active-high; clk and rst naming fixed as above.
  - All ex_* outputs go to 0; ex_jump_t = NO_JUMP; counters go to 0.
  - Combinational outputs depend only on registered state and current inputs, so they are 0 while ex_valid = 0 and no redirect is present.
- Load-use hazard (combinational):
  - lu = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - Compare rs2 even for instructions that do not use it (conservative stall, accepted).
- Priority per cycle, highest first: rst > ext_stall > ex_redirect > lu > normal.
  - ext_stall: all registers and counters hold; stall_pc = stall_ifid = 1; flush_ifid = 0. A pending redirect or lu is re-evaluated on the first cycle after release.
  - ex_redirect: flush_ifid = 1; stall_pc = stall_ifid = 0; ID/EX loads a bubble; flush_cnt += 1.
  - lu: stall_pc = stall_ifid = 1; ID/EX loads a bubble; stall_cnt += 1. The bubble clears lu next cycle, so the penalty is exactly 1 cycle.
  - normal: ID/EX loads all id_* fields; ex_valid <= id_valid.
- Bubble definition:
  - valid = reg_we = mem_read = mem_we = 0; jump_t = NO_JUMP.
  - rd, rs1, rs2 = 0, so the forwarding unit never matches a bubble.
  - Data fields are don't-care, driven 0.
- An ID instruction with id_valid = 0 is also loaded with reg_we/mem_we/mem_read forced 0.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Counters saturate at 2^CNT_W-1; they never wrap.
- Redirect and lu in the same cycle: redirect wins; lu is dropped because the ID instruction is wrong-path. stall_cnt does not increment.
- Reset asserted mid-stall: the next cycle is fully reset with no residual stall.

Decomposition:
- Shared package riscv_pipe_pkg:
  - jump-type constants NO_JUMP = 2'b00, JAL = 2'b01, JAL_R = 2'b10 (the same encoding the forwarding unit uses)
  - register index width 5
  - bubble constant for the control fields
- Sub-module sat_counter (parameter CNT_W; ports clk, rst, hold, inc, count), instantiated twice.

Test Plan:
- Reset: rst = 1 for 2 cycles with random id_* -> all ex_* = 0, ex_jump_t = 2'b00, both counters 0, stall_pc = stall_ifid = flush_ifid = 0.
- Pass-through: id_valid = 1, id_rs1 = 5, id_rs2 = 6, id_rd = 7, id_pc = 0x100, id_jump_t = JAL -> next cycle ex_rs1 = 5, ex_rs2 = 6, ex_rd = 7, ex_pc = 0x100, ex_jump_t = 2'b01, ex_valid = 1.
- Load-use: lw x3 in EX, ID add x4,x3,x1 -> stall_pc = stall_ifid = 1 for exactly 1 cycle; next ex_valid = 0, ex_rd = 0, ex_reg_we = 0; the following cycle add appears in EX; stall_cnt = 1.
- Load to x0: ex_mem_read = 1, ex_rd = 0, id_rs1 = 0 -> no stall; stall_cnt stays 0.
- Redirect with lu: ex_redirect = 1 and the lu condition both true -> flush_ifid = 1, stall_pc = 0, bubble loaded, flush_cnt = 1, stall_cnt = 0.
- ext_stall: assert ext_stall for 3 cycles during a lu condition -> ex_* frozen, counters frozen; after release, 1 bubble is inserted and stall_cnt += 1. Separately, preload the counter to 2^CNT_W-1 and trigger lu -> it stays saturated.
